cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM that sequences the single-issue core: fetch → decode → execute → memory → writeback.
- Owns the PC and instruction register (IR) and drives the IR into the instruction decoder.
- Gates the decoder's static reg_wren/ram_wren into single-cycle strobes and handshakes with the instruction and data memories.
- Sits between the memory ports, the decoder, the ALU and the register file.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TIMEOUT, 16, max FETCH wait cycles before fault (0 = no timeout).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instruction  out  32  IR, feeds decoder
- pc  out  32  current PC
- dec_reg_wren  in  1  decoder register write enable
- dec_ram_wren  in  1  decoder RAM write enable
- dec_reg_write_data_src  in  1  1 = load result from RAM
- dec_next_pc_src  in  2  0 = not branch, 1 = always branch, 2 = branch if ALU result zero, 3 = branch if nonzero
- alu_rd_result  in  32  ALU rd result (branch compare)
- alu_pc_result  in  32  branch/jump target
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (store)
- dmem_ready  in  1  data access complete
- reg_wren  out  1  one-cycle register-file write strobe
- busy  out  1  high except in FETCH while idle-waiting
- fault  out  1  sticky fetch-timeout flag

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT. One state register; all outputs registered or decoded from state.
- Reset (synchronous, rst=1 at posedge):
  - state=FETCH, pc=RESET_PC, IR=32'h0000_0013 (NOP).
  - imem_req, dmem_req, dmem_we, reg_wren, fault = 0.
  - Reset mid-operation aborts any outstanding request; a late imem_ready/dmem_ready is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc, held until imem_ready.
  - On imem_ready: IR<=imem_rdata, imem_req drops next cycle, go DECODE.
  - Wait counter increments per non-ready cycle. If IMEM_TIMEOUT≠0 and counter reaches IMEM_TIMEOUT: fault<=1, go FAULT.
- DECODE: one cycle; decoder outputs settle. Go EXECUTE.
- EXECUTE: one cycle. If dec_ram_wren | dec_reg_write_data_src, go MEMORY; else go WRITEBACK.
- MEMORY:
  - dmem_req=1, dmem_we=dec_ram_wren, held stable until dmem_ready; then go WRITEBACK.
  - No timeout.
- WRITEBACK:
  - reg_wren = dec_reg_wren for exactly this cycle (stores never write).
  - Branch-taken decode: src=1 taken; src=2 taken iff alu_rd_result==0; src=3 taken iff alu_rd_result≠0; src=0 not taken.
  - pc <= taken ? {alu_pc_result[31:2],2'b00} : pc+4. 32-bit wrap: 32'hFFFF_FFFC+4 = 0.
  - Go FETCH.
- FAULT: all requests 0; pc and IR frozen; exits only via rst.
- Latency per instruction, zero-wait memories: ALU/branch/jump = 4 cycles; load/store = 5 cycles. Each wait cycle adds 1.
- imem_ready outside FETCH and dmem_ready outside MEMORY are ignored.

Optional Feature:
- Macro: SEQUENCER_PERF_COUNTERS_EN.
- Defined: adds outputs cycle_count[63:0] and instret_count[63:0], both reset to 0.
  - cycle_count increments every cycle not in reset and not in FAULT.
  - instret_count increments in each WRITEBACK cycle.
  - Both wrap at 2^64.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset release, zero-wait imem with ADDI (32'h0010_0093): imem_req at cycle 0; reg_wren pulses exactly once at cycle 3; pc 0→4; next imem_req at cycle 4.
- Load, dmem_ready delayed 3 cycles: dmem_req held 4 cycles with dmem_we=0; reg_wren 1 cycle after dmem_ready; total 8 cycles.
- Store: dmem_we=1 during MEMORY; reg_wren never asserts.
- BEQ with src=2:
  - alu_rd_result=0, alu_pc_result=32'h0000_0103 → pc=32'h0000_0100.
  - alu_rd_result=5 → pc=old+4.
- pc=32'hFFFF_FFFC, non-branch → pc wraps to 0.
- Fetch timeout and reset mid-operation:
  - imem_ready held low for 16 cycles → fault=1, imem_req=0, state frozen.
  - rst during MEMORY → dmem_req=0 next cycle, pc=RESET_PC, fault cleared.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer; owns PC and IR.
// Latency: 4 cycles per ALU/branch/jump, 5 per load/store, plus 1 per memory wait cycle.
// Backpressure: holds imem_req/dmem_req until the matching ready; FETCH may time out into a sticky FAULT.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   imem_req/addr/ready/rdata      instruction fetch handshake (addr = pc)
//   instruction, pc                IR to the decoder, current PC
//   dec_*                          static decoder outputs for the instruction in IR
//   alu_rd_result, alu_pc_result   branch compare value and branch/jump target
//   dmem_req/we/ready              data access handshake
//   reg_wren                       one-cycle register-file write strobe
//   busy, fault                    sequencer activity, sticky fetch-timeout flag
//   cycle_count, instret_count     only when SEQUENCER_PERF_COUNTERS_EN is defined
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        dec_reg_wren,
  input  logic        dec_ram_wren,
  input  logic        dec_reg_write_data_src,
  input  logic [1:0]  dec_next_pc_src,
  input  logic [31:0] alu_rd_result,
  input  logic [31:0] alu_pc_result,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        reg_wren,
  output logic        busy,
  output logic        fault
`ifdef SEQUENCER_PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] wait_cnt;
  logic        fault_q;
  logic        taken;

  // Branch resolution from the decoder's next-PC select and the ALU compare value.
  always_comb begin
    taken = 1'b0;
    case (dec_next_pc_src)
      2'd0:    taken = 1'b0;
      2'd1:    taken = 1'b1;
      2'd2:    taken = (alu_rd_result == 32'd0);
      default: taken = (alu_rd_result != 32'd0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= NOP;
      wait_cnt <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir_q     <= imem_rdata;
            wait_cnt <= 32'd0;
            state    <= S_DECODE;
          end else if ((IMEM_TIMEOUT != 0) && (wait_cnt == IMEM_TIMEOUT - 1)) begin
            // This is the IMEM_TIMEOUT-th consecutive non-ready cycle.
            fault_q <= 1'b1;
            state   <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_DECODE:  state <= S_EXECUTE;
        S_EXECUTE: state <= (dec_ram_wren || dec_reg_write_data_src) ? S_MEMORY : S_WRITEBACK;
        S_MEMORY: begin
          if (dmem_ready) begin
            state <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          // Targets are forced word-aligned; sequential PC wraps naturally at 32 bits.
          pc_q  <= taken ? {alu_pc_result[31:2], 2'b00} : pc_q + 32'd4;
          state <= S_FETCH;
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

  // Request/strobe outputs decode from state; gating with rst drops them
  // in the very cycle reset is applied so an in-flight access is abandoned.
  assign imem_req    = (state == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign instruction = ir_q;
  assign pc          = pc_q;
  assign dmem_req    = (state == S_MEMORY) && !rst;
  assign dmem_we     = dmem_req && dec_ram_wren;
  assign reg_wren    = (state == S_WRITEBACK) && dec_reg_wren && !rst;
  assign busy        = (state != S_FETCH);
  assign fault       = fault_q;

`ifdef SEQUENCER_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= 64'd0;
      instret_count <= 64'd0;
    end else begin
      if (state != S_FAULT) begin
        cycle_count <= cycle_count + 64'd1;
      end
      if (state == S_WRITEBACK) begin
        instret_count <= instret_count + 64'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] LW   = 32'h0000_2103;
  localparam logic [31:0] SW   = 32'h0020_2023;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;
  localparam logic [31:0] JAL  = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        dec_reg_wren = 1'b0;
  logic        dec_ram_wren = 1'b0;
  logic        dec_reg_write_data_src = 1'b0;
  logic [1:0]  dec_next_pc_src = 2'd0;
  logic [31:0] alu_rd_result = 32'd0;
  logic [31:0] alu_pc_result = 32'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic        reg_wren;
  logic        busy;
  logic        fault;
`ifdef SEQUENCER_PERF_COUNTERS_EN
  logic [63:0] cycle_count;
  logic [63:0] instret_count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instruction(instruction),
    .pc(pc),
    .dec_reg_wren(dec_reg_wren),
    .dec_ram_wren(dec_ram_wren),
    .dec_reg_write_data_src(dec_reg_write_data_src),
    .dec_next_pc_src(dec_next_pc_src),
    .alu_rd_result(alu_rd_result),
    .alu_pc_result(alu_pc_result),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_ready(dmem_ready),
    .reg_wren(reg_wren),
    .busy(busy),
    .fault(fault)
`ifdef SEQUENCER_PERF_COUNTERS_EN
    ,
    .cycle_count(cycle_count),
    .instret_count(instret_count)
`endif
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; inputs set afterwards apply at the coming posedge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Called in a FETCH cycle; returns in the following FETCH cycle.
  task automatic run_alu(input string tag, input logic [31:0] insn, input logic wr,
                         input logic [1:0] src, input logic [31:0] rd, input logic [31:0] pcr,
                         input logic [31:0] start_pc, input logic [31:0] exp_pc);
    imem_ready = 1'b1; imem_rdata = insn;
    dec_reg_wren = wr; dec_ram_wren = 1'b0; dec_reg_write_data_src = 1'b0;
    dec_next_pc_src = src; alu_rd_result = rd; alu_pc_result = pcr;
    #1;
    chk1({tag, "_c0_imem_req"}, imem_req, 1'b1);
    chk32({tag, "_c0_imem_addr"}, imem_addr, start_pc);
    chk1({tag, "_c0_busy"}, busy, 1'b0);
    chk1({tag, "_c0_reg_wren"}, reg_wren, 1'b0);
    next_cycle();
    // A stray imem_ready in DECODE must not reload IR.
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk32({tag, "_c1_ir"}, instruction, insn);
    chk1({tag, "_c1_imem_req"}, imem_req, 1'b0);
    chk1({tag, "_c1_busy"}, busy, 1'b1);
    chk1({tag, "_c1_reg_wren"}, reg_wren, 1'b0);
    next_cycle();
    imem_ready = 1'b0;
    #1;
    chk32({tag, "_c2_ir"}, instruction, insn);
    chk1({tag, "_c2_reg_wren"}, reg_wren, 1'b0);
    chk1({tag, "_c2_dmem_req"}, dmem_req, 1'b0);
    next_cycle();
    #1;
    chk1({tag, "_c3_reg_wren"}, reg_wren, wr);
    chk32({tag, "_c3_pc"}, pc, start_pc);
    next_cycle();
    #1;
    chk1({tag, "_c4_imem_req"}, imem_req, 1'b1);
    chk1({tag, "_c4_reg_wren"}, reg_wren, 1'b0);
    chk32({tag, "_c4_pc"}, pc, exp_pc);
  endtask

  // Load or store with 'waits' non-ready MEMORY cycles before dmem_ready.
  task automatic run_mem(input string tag, input logic [31:0] insn, input logic store,
                         input int waits, input logic [31:0] start_pc);
    imem_ready = 1'b1; imem_rdata = insn;
    dec_reg_wren = !store; dec_ram_wren = store; dec_reg_write_data_src = !store;
    dec_next_pc_src = 2'd0; dmem_ready = 1'b0;
    #1;
    chk32({tag, "_c0_imem_addr"}, imem_addr, start_pc);
    next_cycle();
    imem_ready = 1'b0;
    #1;
    chk1({tag, "_decode_dmem_req"}, dmem_req, 1'b0);
    next_cycle();
    #1;
    chk1({tag, "_execute_dmem_req"}, dmem_req, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      next_cycle();
      dmem_ready = (i == waits);
      #1;
      chk1({tag, "_mem_dmem_req"}, dmem_req, 1'b1);
      chk1({tag, "_mem_dmem_we"}, dmem_we, store);
      chk1({tag, "_mem_reg_wren"}, reg_wren, 1'b0);
    end
    next_cycle();
    dmem_ready = 1'b0;
    #1;
    chk1({tag, "_wb_dmem_req"}, dmem_req, 1'b0);
    chk1({tag, "_wb_reg_wren"}, reg_wren, !store);
    next_cycle();
    #1;
    chk1({tag, "_next_imem_req"}, imem_req, 1'b1);
    chk1({tag, "_next_reg_wren"}, reg_wren, 1'b0);
    chk32({tag, "_next_pc"}, pc, start_pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across two edges.
    next_cycle();
    next_cycle();
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_dmem_we", dmem_we, 1'b0);
    chk1("rst_reg_wren", reg_wren, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk32("rst_pc", pc, 32'h0000_0000);
    chk32("rst_ir", instruction, NOP);

    // Release reset: cycle 0 of the first ADDI.
    next_cycle();
    rst = 1'b0;
    run_alu("addi", ADDI, 1'b1, 2'd0, 32'd0, 32'd0, 32'h0000_0000, 32'h0000_0004);

    run_mem("load", LW, 1'b0, 3, 32'h0000_0004);
    run_mem("store", SW, 1'b1, 0, 32'h0000_0008);

    run_alu("beq_taken", BEQ, 1'b0, 2'd2, 32'd0, 32'h0000_0103, 32'h0000_000C, 32'h0000_0100);
    run_alu("beq_not", BEQ, 1'b0, 2'd2, 32'd5, 32'h0000_0103, 32'h0000_0100, 32'h0000_0104);
    run_alu("bne_taken", BNE, 1'b0, 2'd3, 32'd5, 32'h0000_0200, 32'h0000_0104, 32'h0000_0200);
    run_alu("jal_top", JAL, 1'b1, 2'd1, 32'd0, 32'hFFFF_FFFF, 32'h0000_0200, 32'hFFFF_FFFC);
    run_alu("wrap", ADDI, 1'b1, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h0000_0000);

    // Fetch timeout: this FETCH cycle is the first of 16 non-ready cycles.
    imem_ready = 1'b0;
    for (int i = 1; i < 16; i++) begin
      next_cycle();
    end
    #1;
    chk1("to_c15_fault", fault, 1'b0);
    chk1("to_c15_imem_req", imem_req, 1'b1);
    next_cycle();
    #1;
    chk1("to_c16_fault", fault, 1'b1);
    chk1("to_c16_imem_req", imem_req, 1'b0);
    chk1("to_c16_dmem_req", dmem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
      #1;
    end
    next_cycle();
    imem_ready = 1'b0;
    #1;
    chk1("fault_sticky", fault, 1'b1);
    chk1("fault_imem_req", imem_req, 1'b0);
    chk32("fault_pc", pc, 32'h0000_0000);
    chk32("fault_ir", instruction, ADDI);

    // Reset out of FAULT.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    chk1("unfault_fault", fault, 1'b0);
    chk32("unfault_pc", pc, 32'h0000_0000);
    chk1("unfault_imem_req", imem_req, 1'b1);
    run_alu("post_fault", ADDI, 1'b1, 2'd0, 32'd0, 32'd0, 32'h0000_0000, 32'h0000_0004);

    // Reset while a load is waiting in MEMORY.
    imem_ready = 1'b1; imem_rdata = LW;
    dec_reg_wren = 1'b1; dec_ram_wren = 1'b0; dec_reg_write_data_src = 1'b1;
    dec_next_pc_src = 2'd0; dmem_ready = 1'b0;
    next_cycle();
    imem_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk1("abort_mem_dmem_req", dmem_req, 1'b1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    dmem_ready = 1'b1;
    #1;
    chk1("abort_dmem_req", dmem_req, 1'b0);
    chk32("abort_pc", pc, 32'h0000_0000);
    chk1("abort_fault", fault, 1'b0);
    chk32("abort_ir", instruction, NOP);
    chk1("abort_imem_req", imem_req, 1'b1);
    next_cycle();
    dmem_ready = 1'b0;
    #1;
    chk1("late_ready_imem_req", imem_req, 1'b1);
    chk1("late_ready_dmem_req", dmem_req, 1'b0);
    chk1("late_ready_reg_wren", reg_wren, 1'b0);
    chk1("late_ready_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
